// File: rtl/barrel_spawner.sv
// rtl/barrel_spawner.sv - barrel launch scheduler with LFSR gap/direction and difficulty ramp
// Optional BARREL_SPAWN_FIXED_EN replaces the LFSR output with zero for deterministic runs.
module barrel_spawner #(
    parameter int                MIN_GAP      = 30,
    parameter logic [7:0]        GAP_MASK     = 8'h3F,
    parameter int                ACK_TIMEOUT  = 16,
    parameter int                SPEED_X_BASE = 2,
    parameter int                SPEED_X_MAX  = 6,
    parameter logic signed [8:0] SPEED_Y_INIT = 9'sd0,
    parameter logic [15:0]       LFSR_SEED    = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       game_start,
    input  logic       over,
    input  logic       frame_tick,
    input  logic [1:0] barrel_state,
    output logic       barrel_start,
    output logic [9:0] speed_x,
    output logic [8:0] speed_y,
    output logic [7:0] spawn_count,
    output logic       busy,
    output logic [2:0] fsm_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_GAP    = 3'd1,
        S_LAUNCH = 3'd2,
        S_ACTIVE = 3'd3,
        S_HALT   = 3'd4
    } state_t;

    state_t      state, state_n;
    logic [15:0] lfsr, lfsr_n;
    logic [7:0]  gap_cnt, gap_n;
    logic [15:0] tmo_cnt, tmo_n;
    logic [7:0]  count_n;
    logic [9:0]  sx_n;
    logic [8:0]  sy_n;
    logic [7:0]  rnd8;
    logic [7:0]  gap_load;
    logic [9:0]  base_sum, capped, mag;
    logic [7:0]  count_inc;

    assign lfsr_n = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);

`ifdef BARREL_SPAWN_FIXED_EN
    assign rnd8 = 8'h00;
`else
    assign rnd8 = lfsr[7:0];
`endif

    assign gap_load  = 8'(MIN_GAP) + (rnd8 & GAP_MASK);
    assign base_sum  = 10'(SPEED_X_BASE) + {5'd0, spawn_count[7:3]};
    assign capped    = (base_sum > 10'(SPEED_X_MAX)) ? 10'(SPEED_X_MAX) : base_sum;
    assign mag       = capped + {8'd0, rnd8[1:0]};
    assign count_inc = (spawn_count == 8'hFF) ? 8'hFF : spawn_count + 8'd1;

    assign busy      = (state == S_GAP) || (state == S_LAUNCH) || (state == S_ACTIVE);
    assign fsm_state = state;

    always_comb begin
        state_n = state;
        gap_n   = gap_cnt;
        tmo_n   = tmo_cnt;
        count_n = spawn_count;
        sx_n    = speed_x;
        sy_n    = speed_y;
        if (over) begin
            state_n = S_HALT;
        end else if (!game_start) begin
            state_n = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    count_n = 8'd0;
                    gap_n   = gap_load;
                    state_n = S_GAP;
                end
                S_GAP: begin
                    if (frame_tick) begin
                        if (gap_cnt <= 8'd1) begin
                            state_n = S_LAUNCH;
                            sx_n    = rnd8[2] ? (~mag + 10'd1) : mag;
                            sy_n    = SPEED_Y_INIT;
                            tmo_n   = 16'(ACK_TIMEOUT);
                        end else begin
                            gap_n = gap_cnt - 8'd1;
                        end
                    end
                end
                S_LAUNCH: begin
                    // An ack outranks a timeout expiring on the same clock.
                    if (barrel_state != 2'b00) begin
                        state_n = S_ACTIVE;
                        count_n = count_inc;
                    end else if (frame_tick) begin
                        if (tmo_cnt <= 16'd1) begin
                            state_n = S_GAP;
                            gap_n   = gap_load;
                        end else begin
                            tmo_n = tmo_cnt - 16'd1;
                        end
                    end
                end
                S_ACTIVE: begin
                    if (barrel_state == 2'b00) begin
                        state_n = S_GAP;
                        gap_n   = gap_load;
                    end
                end
                default: state_n = S_HALT;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            lfsr         <= LFSR_SEED;
            gap_cnt      <= 8'd0;
            tmo_cnt      <= 16'd0;
            spawn_count  <= 8'd0;
            speed_x      <= 10'd0;
            speed_y      <= 9'd0;
            barrel_start <= 1'b0;
        end else begin
            state        <= state_n;
            lfsr         <= lfsr_n;
            gap_cnt      <= gap_n;
            tmo_cnt      <= tmo_n;
            spawn_count  <= count_n;
            speed_x      <= sx_n;
            speed_y      <= sy_n;
            barrel_start <= (state_n == S_LAUNCH);
        end
    end

endmodule

// File: tb/tb_barrel_spawner.sv
// tb/tb_barrel_spawner.sv - directed checks of barrel_spawner launch, timeout, ramp, halt and reset
module tb_barrel_spawner;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       game_start = 1'b0;
    logic       over = 1'b0;
    logic       frame_tick = 1'b0;
    logic [1:0] barrel_state = 2'b00;
    logic       barrel_start;
    logic [9:0] speed_x;
    logic [8:0] speed_y;
    logic [7:0] spawn_count;
    logic       busy;
    logic [2:0] fsm_state;

    int n_vec = 0;
    int n_bad = 0;
    int acks  = 0;
    logic [15:0] m_lfsr;
    logic [15:0] last_r;
    logic [9:0]  last_sx;

    typedef struct {
        int acks;
        int exp_base;
        int exp_count;
    } ramp_t;
    ramp_t ramp_tab[4];

    barrel_spawner #(
        .MIN_GAP(4), .GAP_MASK(8'h3F), .ACK_TIMEOUT(8), .SPEED_X_BASE(2),
        .SPEED_X_MAX(6), .SPEED_Y_INIT(-9'sd3), .LFSR_SEED(16'hACE1)
    ) dut (
        .clk(clk), .rst(rst), .game_start(game_start), .over(over),
        .frame_tick(frame_tick), .barrel_state(barrel_state),
        .barrel_start(barrel_start), .speed_x(speed_x), .speed_y(speed_y),
        .spawn_count(spawn_count), .busy(busy), .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    // Reference Galois LFSR, x^16+x^14+x^13+x^11+1
    always @(posedge clk or posedge rst) begin
        if (rst) m_lfsr <= 16'hACE1;
        else     m_lfsr <= {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] rnd();
`ifdef BARREL_SPAWN_FIXED_EN
        return 16'h0000;
`else
        return m_lfsr;
`endif
    endfunction

    function automatic int exp_gap();
        logic [15:0] r;
        r = rnd();
        return 4 + int'(r[7:0] & 8'h3F);
    endfunction

    function automatic logic [9:0] exp_sx(input int cnt, input logic [15:0] r);
        int base;
        logic [9:0] mag;
        base = 2 + cnt / 8;
        if (base > 6) base = 6;
        mag = 10'(base) + {8'd0, r[1:0]};
        return r[2] ? (~mag + 10'd1) : mag;
    endfunction

    function automatic int sat(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Issue g ticks from GAP, each followed by 'space' idle clocks; expect LAUNCH after the g-th
    task automatic do_gap(input int g, input int space, input int cnt);
        for (int i = 0; i < g; i++) begin
            if (i == g - 1) begin
                last_r  = rnd();
                last_sx = exp_sx(cnt, last_r);
            end
            frame_tick = 1'b1;
            step();
            frame_tick = 1'b0;
            if (i == g - 2) chk("gap_not_early", fsm_state, 3'd1);
            if (i < g - 1) repeat (space) step();
        end
        chk("launch_state", fsm_state, 3'd2);
        chk("launch_start", barrel_start, 1'b1);
        chk("launch_busy", busy, 1'b1);
        chk("launch_speed_x", speed_x, last_sx);
        chk("launch_speed_y", speed_y, 9'h1FD);
    endtask

    task automatic ack();
        barrel_state = 2'b11;
        step();
        chk("ack_start", barrel_start, 1'b0);
        chk("ack_state", fsm_state, 3'd3);
        chk("ack_count", spawn_count, sat(acks + 1));
        chk("ack_speed_hold", speed_x, last_sx);
        acks++;
    endtask

    task automatic release_and_launch();
        int g;
        g = exp_gap();
        barrel_state = 2'b00;
        step();
        chk("release_gap", fsm_state, 3'd1);
        do_gap(g, 0, sat(acks));
    endtask

    initial begin
        int g;
        logic [9:0] mag_dut;
        ramp_tab[0] = '{acks: 8,   exp_base: 3, exp_count: 8};
        ramp_tab[1] = '{acks: 32,  exp_base: 6, exp_count: 32};
        ramp_tab[2] = '{acks: 40,  exp_base: 6, exp_count: 40};
        ramp_tab[3] = '{acks: 260, exp_base: 6, exp_count: 255};

        #2 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_start", barrel_start, 1'b0);
        chk("rst_speed_x", speed_x, 10'd0);
        chk("rst_speed_y", speed_y, 9'd0);
        chk("rst_count", spawn_count, 8'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_state", fsm_state, 3'd0);

        // Launch timing with spaced ticks
        g = exp_gap();
        game_start = 1'b1;
        step();
        chk("start_gap", fsm_state, 3'd1);
        chk("start_busy", busy, 1'b1);
        chk("start_count", spawn_count, 8'd0);
        do_gap(g, 2, 0);
        mag_dut = speed_x[9] ? (~speed_x + 10'd1) : speed_x;
        chk("first_mag_range", (mag_dut >= 10'd2 && mag_dut <= 10'd5), 1'b1);

        // Ack, ticks ignored in ACTIVE, reuse
        barrel_state = 2'b01;
        step();
        chk("ack1_start", barrel_start, 1'b0);
        chk("ack1_count", spawn_count, 8'd1);
        chk("ack1_state", fsm_state, 3'd3);
        acks = 1;
        frame_tick = 1'b1;
        repeat (3) step();
        frame_tick = 1'b0;
        chk("active_ignores_tick", fsm_state, 3'd3);
        release_and_launch();

        // Timeout without ack
        frame_tick = 1'b1;
        repeat (7) step();
        chk("tmo_not_early", fsm_state, 3'd2);
        chk("tmo_start_held", barrel_start, 1'b1);
        g = exp_gap();
        step();
        frame_tick = 1'b0;
        chk("tmo_start", barrel_start, 1'b0);
        chk("tmo_state", fsm_state, 3'd1);
        chk("tmo_count", spawn_count, 8'd1);
        do_gap(g, 0, 1);

        // Ack coinciding with the final timeout tick
        frame_tick = 1'b1;
        repeat (7) step();
        barrel_state = 2'b01;
        step();
        frame_tick = 1'b0;
        chk("ack_vs_tmo_state", fsm_state, 3'd3);
        chk("ack_vs_tmo_count", spawn_count, 8'd2);
        acks = 2;
        release_and_launch();

        // Difficulty ramp checkpoints
        for (int t = 0; t < 4; t++) begin
            while (acks < ramp_tab[t].acks) begin
                ack();
                release_and_launch();
            end
            mag_dut = speed_x[9] ? (~speed_x + 10'd1) : speed_x;
            chk("ramp_base", mag_dut - {8'd0, last_r[1:0]}, ramp_tab[t].exp_base);
            chk("ramp_count", spawn_count, ramp_tab[t].exp_count);
        end

        // Game over in LAUNCH
        over = 1'b1;
        step();
        chk("over_launch_state", fsm_state, 3'd4);
        chk("over_launch_start", barrel_start, 1'b0);
        chk("over_launch_busy", busy, 1'b0);
        chk("over_speed_hold", speed_x, last_sx);
        over = 1'b0;
        repeat (2) step();
        chk("halt_held", fsm_state, 3'd4);
        game_start = 1'b0;
        step();
        chk("halt_exit", fsm_state, 3'd0);
        chk("idle_count_kept", spawn_count, 8'd255);

        // Game over in GAP
        game_start = 1'b1;
        step();
        chk("restart_gap", fsm_state, 3'd1);
        chk("restart_count", spawn_count, 8'd0);
        over = 1'b1;
        step();
        chk("over_gap_state", fsm_state, 3'd4);
        over = 1'b0;
        game_start = 1'b0;
        step();
        chk("over_gap_exit", fsm_state, 3'd0);

        // Game over in ACTIVE
        g = exp_gap();
        game_start = 1'b1;
        step();
        do_gap(g, 1, 0);
        barrel_state = 2'b10;
        step();
        chk("act_state", fsm_state, 3'd3);
        chk("act_count", spawn_count, 8'd1);
        over = 1'b1;
        step();
        chk("over_active_state", fsm_state, 3'd4);
        chk("over_active_start", barrel_start, 1'b0);
        over = 1'b0;
        game_start = 1'b0;
        barrel_state = 2'b00;
        step();
        chk("over_active_exit", fsm_state, 3'd0);

        // Asynchronous reset mid-LAUNCH
        g = exp_gap();
        game_start = 1'b1;
        step();
        do_gap(g, 0, 0);
        acks = 0;
        ack();
        release_and_launch();
        #3 rst = 1'b1;
        #1;
        chk("async_rst_start", barrel_start, 1'b0);
        chk("async_rst_speed_x", speed_x, 10'd0);
        chk("async_rst_speed_y", speed_y, 9'd0);
        chk("async_rst_count", spawn_count, 8'd0);
        chk("async_rst_state", fsm_state, 3'd0);
        step();
        rst = 1'b0;
        game_start = 1'b0;
        step();
        chk("post_rst_state", fsm_state, 3'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/barrel_spawner.md
Name: barrel_spawner

Overview:
- Upstream controller for the barrel sprite. It decides when a barrel is launched and with what initial velocity.
- Drives the barrel's start strobe and SPEED_X/SPEED_Y launch values, and watches the barrel's state to know when it is back in the pool.
- Pseudo-random gap timing and direction come from an LFSR.
- Difficulty ramps with the number of barrels launched; everything stops while the game is over.

Parameters:
- MIN_GAP, 30: minimum frame ticks between barrel-idle and the next launch. Must be ≥1.
- GAP_MASK, 8'h3F: AND-mask applied to LFSR bits [7:0] to form the extra random gap. MIN_GAP+GAP_MASK must be ≤255.
- ACK_TIMEOUT, 16: frame ticks allowed in LAUNCH before giving up. Must be ≥1.
- SPEED_X_BASE, 2: initial horizontal speed magnitude.
- SPEED_X_MAX, 6: ceiling of the difficulty-ramped base. SPEED_X_MAX+3 must be ≤511.
- SPEED_Y_INIT, 0: signed 9-bit vertical launch speed.
- LFSR_SEED, 16'hACE1: LFSR reset value. Must be non-zero.

Ports:
- clk, in, 1: system clock.
- rst, in, 1: asynchronous active-high reset.
- game_start, in, 1: level; game running.
- over, in, 1: level; game over.
- frame_tick, in, 1: one-clk pulse per video frame.
- barrel_state, in, 2: barrel FSM state; 2'b00 = idle/inactive, anything else = in flight.
- barrel_start, out, 1: launch request to the barrel.
- speed_x, out, 10: signed launch speed X (two's complement).
- speed_y, out, 9: signed launch speed Y.
- spawn_count, out, 8: acknowledged launches this game, saturating.
- busy, out, 1: high in GAP, LAUNCH or ACTIVE.
- fsm_state, out, 3: IDLE=0, GAP=1, LAUNCH=2, ACTIVE=3, HALT=4.

Behaviour:
- Reset (async, rst=1):
  - Outputs: barrel_start=0, speed_x=0, speed_y=0, spawn_count=0, busy=0, fsm_state=IDLE.
  - Internal: lfsr=LFSR_SEED, gap and timeout counters=0.
  - Reset mid-operation aborts any launch immediately.
- LFSR: 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1. Advances every clk, in every state.
- Priority, evaluated each clk: over → HALT, then game_start=0 → IDLE, then normal transitions.
- IDLE: when game_start=1 and over=0:
  - clear spawn_count;
  - load gap = MIN_GAP + (lfsr[7:0] & GAP_MASK);
  - go to GAP.
- GAP:
  - Each frame_tick decrements gap.
  - A frame_tick with gap==1 goes to LAUNCH, so LAUNCH is entered exactly G ticks after loading.
  - On the LAUNCH entry edge:
    - latch mag = min(SPEED_X_BASE + spawn_count[7:3], SPEED_X_MAX) + lfsr[1:0];
    - latch speed_x = lfsr[2] ? -mag : +mag;
    - latch speed_y = SPEED_Y_INIT;
    - load timeout = ACK_TIMEOUT.
- LAUNCH:
  - barrel_start=1 (registered; high the clk after entry).
  - barrel_state≠00 is the ack → ACTIVE, barrel_start=0, spawn_count+1 (saturates at 255).
  - If ack and a timeout expiry coincide, ack wins.
  - Timeout: each frame_tick decrements timeout; at 1, barrel_start=0, reload gap (new random), go to GAP. spawn_count is unchanged.
- ACTIVE:
  - barrel_start=0.
  - When barrel_state==00, reload gap (new random) and go to GAP.
- HALT:
  - barrel_start=0; speed outputs hold their last values.
  - Leave to IDLE only when over=0 and game_start=0.
- speed_x/speed_y change only on the LAUNCH entry edge (or reset). They are stable throughout LAUNCH and ACTIVE.
- frame_tick is ignored in IDLE, ACTIVE and HALT.

Optional Feature:
- Macro: BARREL_SPAWN_FIXED_EN.
- Defined:
  - LFSR output is bypassed with zero: gap = MIN_GAP, random speed bonus = 0, direction always positive.
  - speed_x = +min(SPEED_X_BASE + spawn_count[7:3], SPEED_X_MAX).
  - Used for deterministic simulation.
- Undefined: LFSR behaviour as specified above.

Test Plan:
All scenarios use BARREL_SPAWN_FIXED_EN, MIN_GAP=4, ACK_TIMEOUT=8, SPEED_X_BASE=2, SPEED_X_MAX=6, SPEED_Y_INIT=-3.
1. Reset: assert rst mid-LAUNCH → barrel_start=0, speed_x=0, speed_y=0, spawn_count=0, fsm_state=0, asynchronously (before the next clk edge).
2. Launch timing: game_start=1, then 4 frame_ticks → barrel_start=1 one clk after the 4th tick; speed_x=+2 (10'h002), speed_y=-3 (9'h1FD).
3. Ack and reuse:
   - barrel_state=01 in LAUNCH → barrel_start=0 next clk, spawn_count=1, fsm_state=3.
   - barrel_state=00 → GAP; relaunch after 4 more ticks.
4. Timeout: no ack for 8 ticks in LAUNCH → barrel_start=0, spawn_count unchanged, fsm_state=1, relaunch after 4 more ticks. Ack on the same clk as the 8th tick → ACTIVE.
5. Difficulty ramp:
   - after 8 acks speed_x=+3;
   - after 32 acks speed_x=+6;
   - after 40 acks still +6;
   - after 260 acks spawn_count=255.
6. Game over: over=1 in GAP, LAUNCH or ACTIVE → fsm_state=4, barrel_start=0 next clk. Holding game_start=1 keeps HALT; game_start=0 and over=0 → IDLE. Repeat the whole bench without the macro and check |speed_x| in 2..5 and gaps in 4..67 ticks.
